// File: rtl/gf_exp_param.sv
// GF(2^M) exponentiator b = base^a (polynomial basis, LSB-first square-and-multiply, one exponent bit per cycle).
// Optional macro GF_EXP_INV_EN adds an 'inv' input that forces the exponent to 2^M-2 (field inversion).
module gf_exp_param #(
    parameter int              M    = 13,
    parameter logic [M-1:0]    POLY = 13'h001B
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sel_alpha,
    input  logic [M-1:0] base_in,
    input  logic [M-1:0] a,
`ifdef GF_EXP_INV_EN
    input  logic         inv,
`endif
    output logic         busy,
    output logic         done,
    output logic [M-1:0] b
);

    localparam int           CNT_W    = (M > 1) ? $clog2(M) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);
    localparam logic [M-1:0] ALPHA    = M'(2);
    localparam logic [M-1:0] ONE      = M'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_reg, state_next;
    logic [M-1:0]     e_reg, e_next;
    logic [M-1:0]     sq_reg, sq_next;
    logic [M-1:0]     r_reg, r_next;
    logic [M-1:0]     b_reg, b_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic [M-1:0]     exp_in;
    logic [M-1:0]     mul_r, mul_sq;

    // MSB-first shift-and-add product; each step multiplies the accumulator by x and reduces by POLY.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
        logic [M-1:0] p;
        p = '0;
        for (int i = M - 1; i >= 0; i--) begin
            p = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY : '0);
            if (y[i])
                p = p ^ x;
        end
        return p;
    endfunction

`ifdef GF_EXP_INV_EN
    assign exp_in = inv ? {{(M-1){1'b1}}, 1'b0} : a;
`else
    assign exp_in = a;
`endif

    assign mul_r  = gf_mul(r_reg, sq_reg);
    assign mul_sq = gf_mul(sq_reg, sq_reg);

    always_comb begin
        state_next = state_reg;
        e_next     = e_reg;
        sq_next    = sq_reg;
        r_next     = r_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    e_next     = exp_in;
                    sq_next    = sel_alpha ? ALPHA : base_in;
                    r_next     = ONE;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (e_reg[cnt_reg])
                    r_next = mul_r;
                sq_next  = mul_sq;
                cnt_next = cnt_reg + 1'b1;
                // Last exponent bit: publish the updated accumulator directly.
                if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    b_next     = e_reg[cnt_reg] ? mul_r : r_reg;
                    done_next  = 1'b1;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            e_reg     <= '0;
            sq_reg    <= '0;
            r_reg     <= '0;
            b_reg     <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            e_reg     <= e_next;
            sq_reg    <= sq_next;
            r_reg     <= r_next;
            b_reg     <= b_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = done_reg;
    assign b    = b_reg;

endmodule

// File: tb/tb_gf_exp_param.sv
// Scoreboard bench for gf_exp_param (M=13): stimulus pushes expected results, a monitor pops them on done.
// Reference powers come from exp/log tables of alpha; GF_EXP_INV_EN enables the inversion tests.
module tb_gf_exp_param;

    localparam int           M    = 13;
    localparam logic [M-1:0] POLY = 13'h001B;
    localparam int           N    = (1 << M) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sel_alpha = 1'b0;
    logic [M-1:0] base_in = '0;
    logic [M-1:0] a = '0;
`ifdef GF_EXP_INV_EN
    logic         inv = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [M-1:0] b;

    gf_exp_param #(.M(M), .POLY(POLY)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .sel_alpha(sel_alpha),
        .base_in(base_in),
        .a(a),
`ifdef GF_EXP_INV_EN
        .inv(inv),
`endif
        .busy(busy),
        .done(done),
        .b(b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [M-1:0] exp_b;
        int           exp_cyc;
        string        tag;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           passes = 0;
    int           dones = 0;
    int           issued = 0;
    logic [M-1:0] last_b = '0;
    int           exp_tab[0:N-1];
    int           log_tab[0:N];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int model_pow(input int base, input int e);
        if (e == 0) return 1;
        if (base == 0) return 0;
        return exp_tab[(log_tab[base] * e) % N];
    endfunction

    function automatic int model_mul(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return exp_tab[(log_tab[x] + log_tab[y]) % N];
    endfunction

    // Monitor: every done pops one expectation; b must hold between completions.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_b = '0;
        end else if (done) begin
            dones++;
            check("done_while_busy", int'(busy), 0);
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL spurious_done: got done at cycle %0d, expected no pending op", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.tag, "_b"}, int'(b), int'(e.exp_b));
                check({e.tag, "_latency"}, cyc, e.exp_cyc);
            end
            last_b = b;
        end else begin
            check("b_hold", int'(b), int'(last_b));
        end
    end

    // Called at a negedge with the DUT idle; the request is accepted at the next rising edge.
    task automatic issue_exp(input logic s, input logic [M-1:0] bi, input logic [M-1:0] ai,
                             input logic iv, input int expv, input string tag);
        start = 1'b1; sel_alpha = s; base_in = bi; a = ai;
`ifdef GF_EXP_INV_EN
        inv = iv;
`endif
        @(posedge clk);
        #1;
        sbq.push_back('{M'(expv), cyc + M, tag});
        issued++;
        check({tag, "_accept_busy"}, int'(busy), 1);
        start = 1'b0; sel_alpha = 1'($urandom); base_in = M'($urandom); a = M'($urandom);
`ifdef GF_EXP_INV_EN
        inv = 1'($urandom);
`endif
    endtask

    task automatic issue(input logic s, input logic [M-1:0] bi, input logic [M-1:0] ai,
                         input logic iv, input string tag);
        int e;
        e = int'(ai);
`ifdef GF_EXP_INV_EN
        if (iv) e = N - 1;
`endif
        issue_exp(s, bi, ai, iv, model_pow(s ? 2 : int'(bi), e), tag);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            checks++;
            $display("FAIL wait_idle: got busy after %0d cycles, expected idle", k);
        end
    endtask

    initial begin
        int v;
        logic [M-1:0] prev;
        v = 1;
        for (int i = 0; i < N; i++) begin
            exp_tab[i] = v;
            log_tab[v] = i;
            v = v << 1;
            if (v & (1 << M)) v = (v ^ (1 << M)) ^ int'(POLY);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_b", int'(b), 0);
        rst_n = 1'b1;

        // Directed alpha powers and boundaries
        wait_idle(); issue_exp(1, 0, 0, 0, 13'h0001, "alpha_a0");
        wait_idle(); issue_exp(1, 0, 1, 0, 13'h0002, "alpha_a1");
        wait_idle(); issue_exp(1, 0, 13, 0, 13'h001B, "alpha_a13");
        wait_idle(); issue_exp(1, 0, 13'h1FFF, 0, 13'h0001, "alpha_amax");
        wait_idle(); issue_exp(0, 0, 5, 0, 13'h0000, "zero_a5");
        wait_idle(); issue_exp(0, 0, 0, 0, 13'h0001, "zero_a0");
        wait_idle(); issue_exp(0, 13'h0ABC, 13'h1FFF, 0, 13'h0001, "base_amax");

        // Start while busy is ignored; start in the done cycle is accepted
        wait_idle(); issue(0, 13'h0123, 13'h0456, 0, "busy_first");
        repeat (2) @(negedge clk);
        start = 1'b1; a = 13'h0007; base_in = 13'h0999;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; sel_alpha = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_idle();
        check("b2b_done_cycle", int'(done), 1);
        issue(1, 0, 13'h0100, 0, "b2b_second");

        // Reset in the middle of an operation
        wait_idle(); issue(0, 13'h0321, 13'h0777, 0, "aborted");
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        issued--;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_b", int'(b), 0);
        check("abort_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_idle(); issue_exp(1, 0, 13, 0, 13'h001B, "after_reset");

`ifdef GF_EXP_INV_EN
        wait_idle(); issue_exp(0, 13'h0002, 13'h0055, 1, 13'h100D, "inv_alpha");
        wait_idle();
        prev = b;
        issue(0, prev, 1, 0, "inv_reuse");
        wait_idle();
        check("inv_product", model_mul(int'(b), 2), 1);
        issue_exp(0, 0, 13'h0033, 1, 13'h0000, "inv_zero");
`endif

        // Randomised back-to-back operations
        for (int n = 0; n < 1000; n++) begin
            logic [M-1:0] ra, rb;
            logic iv;
            ra = M'($urandom);
            rb = M'($urandom);
            iv = 1'b0;
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: ra = '0;
                    1: ra = M'(1);
                    2: ra = M'(N);
                    default: ra = M'(N - 1);
                endcase
            end
            if ($urandom_range(15) == 0) rb = '0;
`ifdef GF_EXP_INV_EN
            iv = ($urandom_range(7) == 0);
`endif
            wait_idle();
            issue(1'($urandom_range(3) == 0), rb, ra, iv, "rand");
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        check("done_count", dones, issued);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
